// File: rtl/capi_cmd_cred_rtn.sv
// -----------------------------------------------------------------------------
// capi_cmd_cred_rtn
//
// Responder-side credit manager for the CAPI command credit interface.
// Commands from a credit-limited initiator are buffered in a circular FIFO of
// `depth` entries. `depth` is advertised as the initial credit count, and one
// credit is returned for every entry drained downstream.
//
// Build option:
//   CAPI_CMD_CRED_RTN_COALESCE_EN
//     defined   : returns are coalesced by a small FSM (pending count P, age
//                 timer T) and leave on the batched add bus; o_cred_inc_v = 0.
//     undefined : every pop is returned one cycle later on o_cred_inc_v;
//                 the add bus is tied off.
//
// Reset is synchronous and active-high. Both sides of the credit link must be
// reset together, because the initiator reloads o_init_cred after its reset.
// -----------------------------------------------------------------------------
module capi_cmd_cred_rtn #(
    parameter int cred_width  = 9,
    parameter int data_width  = 64,
    parameter int depth       = 64,
    parameter int rtn_thresh  = 8,
    parameter int rtn_timeout = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_cmd_v,
    input  logic [data_width-1:0] i_cmd_d,
    output logic                  o_cmd_v,
    input  logic                  i_cmd_r,
    output logic [data_width-1:0] o_cmd_d,
    output logic [cred_width-1:0] o_init_cred,
    output logic                  o_cred_add_v,
    output logic [cred_width-1:0] o_cred_add_d,
    output logic                  o_cred_inc_v,
    output logic [cred_width-1:0] o_occupancy,
    output logic                  o_overflow
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int                    ptr_width = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [ptr_width-1:0]  last_ptr  = ptr_width'(depth - 1);
    localparam logic [cred_width-1:0] depth_c   = cred_width'(depth);

    // -------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [data_width-1:0] mem [depth];
    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic [cred_width-1:0] occupancy;
    logic                  overflow_q;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign empty = (occupancy == '0);
    assign full  = (occupancy == depth_c);

    // The head is only presented when something is stored, so a push into an
    // empty FIFO never bypasses straight to the output in the same cycle.
    assign o_cmd_v = !empty;
    assign pop     = o_cmd_v & i_cmd_r;

    // A push while full is still accepted when the head leaves in the same
    // cycle; otherwise it is dropped and recorded as an overflow.
    assign push = i_cmd_v & (!full | pop);
    assign drop = i_cmd_v & full & !pop;

    assign o_cmd_d     = mem[rd_ptr];
    assign o_init_cred = depth_c;
    assign o_occupancy = occupancy;
    assign o_overflow  = overflow_q;

    // Payload write into the slot addressed by the write pointer.
    // NOTE: the storage array has no reset; its contents are only observable
    // through o_cmd_d while o_cmd_v is high, which implies the slot was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_cmd_d;
        end
    end

    // Write and read pointers, each wrapping modulo depth.
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy counter: unchanged when a push and a pop coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef CAPI_CMD_CRED_RTN_COALESCE_EN

    // -------------------------------------------------------------------------
    // Coalescing credit return
    //   EMPTY : nothing pending. A pop either flushes immediately (threshold of
    //           one) or starts an accumulation with P=1, T=0.
    //   ACCUM : P credits pending, oldest one aged T cycles. The sum including
    //           this cycle's pop is flushed when it reaches the threshold or
    //           when T hits the timeout, so the triggering pop is never lost.
    // -------------------------------------------------------------------------
    localparam logic [0:0]            st_empty = 1'b0;
    localparam logic [0:0]            st_accum = 1'b1;
    localparam logic [cred_width-1:0] thresh_c = cred_width'(rtn_thresh);
    localparam logic [7:0]            age_last = 8'(rtn_timeout - 1);

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic [cred_width-1:0] pend;
    logic [cred_width-1:0] pend_nxt;
    logic [cred_width-1:0] sum;
    logic [7:0]            age;
    logic [7:0]            age_nxt;
    logic                  flush;
    logic                  add_v_q;
    logic [cred_width-1:0] add_d_q;

    // Next-state decision for the return FSM.
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        age_nxt   = age;
        flush     = 1'b0;
        sum       = pend + cred_width'(pop);
        case (state)
            st_empty: begin
                if (pop) begin
                    if (rtn_thresh == 1) begin
                        flush = 1'b1;
                    end else begin
                        pend_nxt  = cred_width'(1);
                        age_nxt   = '0;
                        state_nxt = st_accum;
                    end
                end
            end
            st_accum: begin
                if ((sum >= thresh_c) || (age == age_last)) begin
                    flush     = 1'b1;
                    pend_nxt  = '0;
                    age_nxt   = '0;
                    state_nxt = st_empty;
                end else begin
                    pend_nxt = sum;
                    age_nxt  = age + 8'd1;
                end
            end
            default: begin
                pend_nxt  = '0;
                age_nxt   = '0;
                state_nxt = st_empty;
            end
        endcase
    end

    // FSM state, pending count and age timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= st_empty;
            pend  <= '0;
            age   <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            age   <= age_nxt;
        end
    end

    // Registered single-cycle batched return; the count reads zero when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_v_q <= 1'b0;
            add_d_q <= '0;
        end else begin
            add_v_q <= flush;
            add_d_q <= flush ? sum : '0;
        end
    end

    assign o_cred_add_v = add_v_q;
    assign o_cred_add_d = add_d_q;
    assign o_cred_inc_v = 1'b0;

`else

    // -------------------------------------------------------------------------
    // Immediate credit return: one increment strobe per pop, one cycle later.
    // -------------------------------------------------------------------------
    logic inc_v_q;

    // Registered copy of the pop strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            inc_v_q <= 1'b0;
        end else begin
            inc_v_q <= pop;
        end
    end

    assign o_cred_inc_v = inc_v_q;
    assign o_cred_add_v = 1'b0;
    assign o_cred_add_d = '0;

`endif

endmodule

// File: tb/tb_capi_cmd_cred_rtn.sv
// -----------------------------------------------------------------------------
// tb_capi_cmd_cred_rtn
//
// Self-checking bench for capi_cmd_cred_rtn. A behavioural model (a queue for
// the FIFO, a pending count plus the cycle of the oldest unreturned pop for
// the coalesced return, an integer for the initiator's credit counter) is
// stepped alongside the DUT and every output is compared after every edge.
// Follows the CAPI_CMD_CRED_RTN_COALESCE_EN build of the design.
// -----------------------------------------------------------------------------
module tb_capi_cmd_cred_rtn;

    localparam int c_cred_w  = 9;
    localparam int c_data_w  = 64;
    localparam int c_depth   = 64;
    localparam int c_thresh  = 8;
    localparam int c_timeout = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                i_cmd_v;
    logic [c_data_w-1:0] i_cmd_d;
    logic                o_cmd_v;
    logic                i_cmd_r;
    logic [c_data_w-1:0] o_cmd_d;
    logic [c_cred_w-1:0] o_init_cred;
    logic                o_cred_add_v;
    logic [c_cred_w-1:0] o_cred_add_d;
    logic                o_cred_inc_v;
    logic [c_cred_w-1:0] o_occupancy;
    logic                o_overflow;

    capi_cmd_cred_rtn #(
        .cred_width (c_cred_w),
        .data_width (c_data_w),
        .depth      (c_depth),
        .rtn_thresh (c_thresh),
        .rtn_timeout(c_timeout)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_v     (i_cmd_v),
        .i_cmd_d     (i_cmd_d),
        .o_cmd_v     (o_cmd_v),
        .i_cmd_r     (i_cmd_r),
        .o_cmd_d     (o_cmd_d),
        .o_init_cred (o_init_cred),
        .o_cred_add_v(o_cred_add_v),
        .o_cred_add_d(o_cred_add_d),
        .o_cred_inc_v(o_cred_inc_v),
        .o_occupancy (o_occupancy),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [63:0] m_q[$];       // FIFO contents, head at index 0
    bit          m_ovf;
    int          m_pend;       // popped but not yet returned
    int          m_t_old;      // cycle of the oldest unreturned pop
    int          m_cyc;
    int          m_cred;       // initiator's credit counter
    bit          m_cred_ok;    // initiator has respected its credits since reset
    bit          e_add_v;
    int          e_add_d;
    bit          e_inc_v;

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input bit v, input logic [63:0] d, input bit r, input bit rst);
        int  inflight;
        int  s;
        bit  pop;
        reset   = rst;
        i_cmd_v = v;
        i_cmd_d = d;
        i_cmd_r = r;
        inflight = (o_cred_add_v ? int'(o_cred_add_d) : 0) + int'(o_cred_inc_v);
        m_cyc++;
        if (rst) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_pend    = 0;
            m_cred    = c_depth;
            m_cred_ok = 1'b1;
            e_add_v   = 1'b0;
            e_add_d   = 0;
            e_inc_v   = 1'b0;
        end else begin
            pop = r && (m_q.size() > 0);
            if (pop) void'(m_q.pop_front());
            if (v) begin
                if (m_q.size() < c_depth) m_q.push_back(d);
                else m_ovf = 1'b1;
                if (m_cred <= 0) m_cred_ok = 1'b0;
            end
            m_cred = m_cred - int'(v) + inflight;
`ifdef CAPI_CMD_CRED_RTN_COALESCE_EN
            s       = m_pend + int'(pop);
            e_add_v = 1'b0;
            e_add_d = 0;
            e_inc_v = 1'b0;
            if (s > 0 && (s >= c_thresh || (m_pend > 0 && m_cyc - m_t_old == c_timeout))) begin
                e_add_v = 1'b1;
                e_add_d = s;
                m_pend  = 0;
            end else begin
                if (m_pend == 0 && pop) m_t_old = m_cyc;
                m_pend = s;
            end
`else
            s       = 0;
            e_add_v = 1'b0;
            e_add_d = 0;
            e_inc_v = pop;
`endif
        end
        @(posedge clk);
        #1;
        check("occupancy", 64'(o_occupancy), 64'(m_q.size()));
        check("cmd_v", 64'(o_cmd_v), 64'(m_q.size() > 0));
        if (m_q.size() > 0) check("cmd_d", o_cmd_d, m_q[0]);
        check("overflow", 64'(o_overflow), 64'(m_ovf));
        check("cred_add_v", 64'(o_cred_add_v), 64'(e_add_v));
        check("cred_add_d", 64'(o_cred_add_d), 64'(e_add_d));
        check("cred_inc_v", 64'(o_cred_inc_v), 64'(e_inc_v));
        check("init_cred", 64'(o_init_cred), 64'(c_depth));
        if (m_cred_ok) begin
            check("credit_invariant",
                  64'(m_cred + int'(o_occupancy) + m_pend +
                      (o_cred_add_v ? int'(o_cred_add_d) : 0) + int'(o_cred_inc_v)),
                  64'(c_depth));
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 1'b0, 1'b1);
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        bit          v;
        logic [63:0] d;
        bit          r;
        int          occ;
        bit          cmd_v;
        logic [63:0] head;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          pulse_d[$];
        int          pulse_at[$];
        logic [63:0] late;
        int          exp_d[3];
        int          exp_at[3];

        tbl[0] = '{1'b1, 64'hA0A0, 1'b0, 1, 1'b1, 64'hA0A0};  // push into empty
        tbl[1] = '{1'b1, 64'hB1B1, 1'b1, 1, 1'b1, 64'hB1B1};  // push + pop
        tbl[2] = '{1'b1, 64'hC2C2, 1'b0, 2, 1'b1, 64'hB1B1};  // push
        tbl[3] = '{1'b0, 64'h0,    1'b1, 1, 1'b1, 64'hC2C2};  // pop
        tbl[4] = '{1'b0, 64'h0,    1'b1, 0, 1'b0, 64'h0};     // pop to empty
        tbl[5] = '{1'b1, 64'hD3D3, 1'b1, 1, 1'b1, 64'hD3D3};  // push+pop on empty: no bypass
        tbl[6] = '{1'b0, 64'h0,    1'b1, 0, 1'b0, 64'h0};     // pop to empty
        tbl[7] = '{1'b0, 64'h0,    1'b1, 0, 1'b0, 64'h0};     // pop on empty is ignored

        m_cyc  = 0;
        m_cred = c_depth;
        m_pend = 0;

        // Reset: hold for three cycles, then check every output.
        do_reset(3);
        check("rst_cmd_v", 64'(o_cmd_v), 64'h0);
        check("rst_occupancy", 64'(o_occupancy), 64'h0);
        check("rst_overflow", 64'(o_overflow), 64'h0);
        check("rst_add_v", 64'(o_cred_add_v), 64'h0);
        check("rst_add_d", 64'(o_cred_add_d), 64'h0);
        check("rst_inc_v", 64'(o_cred_inc_v), 64'h0);
        check("rst_init_cred", 64'(o_init_cred), 64'd64);

        // Table-driven FIFO basics.
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            check($sformatf("tbl%0d_occ", i), 64'(o_occupancy), 64'(tbl[i].occ));
            check($sformatf("tbl%0d_cmd_v", i), 64'(o_cmd_v), 64'(tbl[i].cmd_v));
            if (tbl[i].cmd_v) check($sformatf("tbl%0d_head", i), o_cmd_d, tbl[i].head);
        end

        // Fill to full, then overflow, then push+pop while full, then drain.
        do_reset(1);
        for (int i = 0; i < c_depth; i++) cycle(1'b1, 64'h1000 + 64'(i), 1'b0, 1'b0);
        check("fill_occ", 64'(o_occupancy), 64'd64);
        check("fill_no_ovf", 64'(o_overflow), 64'h0);
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);
        check("ovf_set", 64'(o_overflow), 64'h1);
        check("ovf_occ", 64'(o_occupancy), 64'd64);
        check("ovf_head", o_cmd_d, 64'h1000);
        late = 64'hBEEF;
        cycle(1'b1, late, 1'b1, 1'b0);
        check("full_pushpop_occ", 64'(o_occupancy), 64'd64);
        check("full_pushpop_head", o_cmd_d, 64'h1001);
        for (int i = 0; i < c_depth - 1; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check("drain_last_head", o_cmd_d, late);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check("drain_empty", 64'(o_cmd_v), 64'h0);
        check("ovf_sticky", 64'(o_overflow), 64'h1);

`ifdef CAPI_CMD_CRED_RTN_COALESCE_EN
        // Threshold flush: fill 20, drain continuously, then idle.
        do_reset(1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 64'h2000 + 64'(i), 1'b0, 1'b0);
        for (int i = 1; i <= 50; i++) begin
            cycle(1'b0, 64'h0, (i <= 20), 1'b0);
            if (o_cred_add_v) begin
                pulse_d.push_back(int'(o_cred_add_d));
                pulse_at.push_back(i);
            end
        end
        exp_d  = '{8, 8, 4};
        exp_at = '{8, 16, 17 + c_timeout};
        check("thresh_pulse_count", 64'(pulse_d.size()), 64'd3);
        for (int k = 0; k < 3 && k < pulse_d.size(); k++) begin
            check($sformatf("thresh_pulse%0d_d", k), 64'(pulse_d[k]), 64'(exp_d[k]));
            check($sformatf("thresh_pulse%0d_at", k), 64'(pulse_at[k]), 64'(exp_at[k]));
        end

        // Timeout flush: one push, one pop, then idle.
        do_reset(1);
        pulse_d.delete();
        pulse_at.delete();
        cycle(1'b1, 64'h3333, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            cycle(1'b0, 64'h0, 1'b0, 1'b0);
            if (o_cred_add_v) begin
                pulse_d.push_back(int'(o_cred_add_d));
                pulse_at.push_back(i);
            end
        end
        check("timeout_pulse_count", 64'(pulse_d.size()), 64'd1);
        if (pulse_d.size() > 0) begin
            check("timeout_d", 64'(pulse_d[0]), 64'd1);
            check("timeout_at", 64'(pulse_at[0]), 64'(c_timeout));
        end
`else
        // Immediate returns: five pops on alternate cycles.
        do_reset(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 64'h4000 + 64'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 64'h0, (i % 2 == 0), 1'b0);
            if (o_cred_inc_v) pulse_at.push_back(i);
        end
        check("inc_pulse_count", 64'(pulse_at.size()), 64'd5);
        for (int k = 0; k < 5 && k < pulse_at.size(); k++)
            check($sformatf("inc_pulse%0d_at", k), 64'(pulse_at[k]), 64'(2 * k));
`endif

        // Random traffic respecting credits: fill phase, then drain phase.
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit r;
            v = (m_cred > 0) && ($urandom_range(7, 0) != 0);
            r = (i < 200) ? ($urandom_range(7, 0) == 0) : ($urandom_range(3, 0) != 0);
            cycle(v, {$urandom, $urandom}, r, 1'b0);
        end

        // Reset in the middle of traffic: everything discarded, no return.
        for (int i = 0; i < 6; i++) cycle(1'b1, 64'h5000 + 64'(i), 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b1);
        check("midrst_occ", 64'(o_occupancy), 64'h0);
        check("midrst_add_v", 64'(o_cred_add_v), 64'h0);
        check("midrst_inc_v", 64'(o_cred_inc_v), 64'h0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 64'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
